// File: rtl/unit_test_pkg.sv
// Shared constants for the unit_test result-reporting block: register
// offsets inside the 16-byte window and default parameter values.
package unit_test_pkg;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h1000_0000;
  localparam int          DEF_CNT_W     = 16;

  localparam logic [3:0] OFF_TEST_ID = 4'h0;
  localparam logic [3:0] OFF_RESULT  = 4'h4;
  localparam logic [3:0] OFF_DONE    = 4'h8;
endpackage

// File: rtl/unit_test_sat_counter.sv
// Increment-only counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 cnt <= '0;
    else if (inc && (cnt != '1)) cnt <= cnt + {{(WIDTH-1){1'b0}}, 1'b1};
  end
endmodule

// File: rtl/unit_test.sv
// Memory-mapped test-result sink: software writes TEST_ID / RESULT / DONE
// and the block keeps pass/fail counters and the last failure record.
// Optional console logging and $finish on DONE with UNIT_TEST_LOG_EN.
module unit_test
  import unit_test_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      dmem_addr,
  input  logic [3:0]       dmem_wmask,
  input  logic [31:0]      dmem_wdata,
  output logic             dmem_ready,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [31:0]      last_fail_id,
  output logic [31:0]      last_fail_code,
  output logic [31:0]      exit_code
);
  logic        hit, commit, res_wr, pass_inc, fail_inc;
  logic [3:0]  off;
  logic [31:0] test_id;
  logic        unused_bits;

  // Byte lanes within a word are not decoded; any strobe writes the full word.
  assign unused_bits = ^dmem_addr[1:0];
  assign off         = {dmem_addr[3:2], 2'b00};

  // Suppressing hit while ready is high turns a held request into one ack per two cycles.
  assign hit      = (|dmem_wmask) && (dmem_addr[31:4] == BASE_ADDR[31:4]) && !dmem_ready;
  assign commit   = hit && !done;
  assign res_wr   = commit && (off == OFF_RESULT);
  assign pass_inc = res_wr && (dmem_wdata == 32'h0);
  assign fail_inc = res_wr && (dmem_wdata != 32'h0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dmem_ready     <= 1'b0;
      done           <= 1'b0;
      test_id        <= '0;
      last_fail_id   <= '0;
      last_fail_code <= '0;
      exit_code      <= '0;
    end else begin
      dmem_ready <= hit;
      if (commit) begin
        case (off)
          OFF_TEST_ID: test_id <= dmem_wdata;
          OFF_RESULT: if (fail_inc) begin
            last_fail_id   <= test_id;
            last_fail_code <= dmem_wdata;
          end
          OFF_DONE: begin
            done      <= 1'b1;
            exit_code <= dmem_wdata;
          end
          default: ;
        endcase
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_pass_cnt (
    .clk(clk), .resetn(resetn), .inc(pass_inc), .cnt(pass_cnt)
  );
  sat_counter #(.WIDTH(CNT_W)) u_fail_cnt (
    .clk(clk), .resetn(resetn), .inc(fail_inc), .cnt(fail_cnt)
  );

`ifdef UNIT_TEST_LOG_EN
  always @(posedge clk) begin
    if (resetn && pass_inc) $display("test %0d PASS", test_id);
    if (resetn && fail_inc) $display("test %0d FAIL code %h", test_id, dmem_wdata);
    if (resetn && commit && (off == OFF_DONE)) begin
      $display("unit_test done: %0d passed, %0d failed, exit %h", pass_cnt, fail_cnt, dmem_wdata);
      $finish;
    end
  end
`endif
endmodule

// File: tb/tb_unit_test.sv
// Directed bench for unit_test: handshake timing, register effects,
// saturation (narrow instance), post-DONE lockout and async reset.
module tb_unit_test;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  wmask = '0;
  logic [31:0] wdata = '0;

  logic        ready, done;
  logic [15:0] pass_cnt, fail_cnt;
  logic [31:0] lf_id, lf_code, exit_code;

  logic        s_ready, s_done;
  logic [1:0]  s_pass, s_fail;
  logic [31:0] s_lf_id, s_lf_code, s_exit;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  unit_test dut (
    .clk(clk), .resetn(resetn), .dmem_addr(addr), .dmem_wmask(wmask), .dmem_wdata(wdata),
    .dmem_ready(ready), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .last_fail_id(lf_id), .last_fail_code(lf_code), .exit_code(exit_code)
  );

  unit_test #(.CNT_W(2)) dut_s (
    .clk(clk), .resetn(resetn), .dmem_addr(addr), .dmem_wmask(wmask), .dmem_wdata(wdata),
    .dmem_ready(s_ready), .done(s_done), .pass_cnt(s_pass), .fail_cnt(s_fail),
    .last_fail_id(s_lf_id), .last_fail_code(s_lf_code), .exit_code(s_exit)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Single write: ready must be low when presented, high for exactly one cycle after.
  task automatic wr(input string tag, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    @(negedge clk); addr = a; wmask = m; wdata = d;
    #1 chk({tag, "_pre"}, {31'b0, ready}, 32'd0);
    @(posedge clk); #1 chk({tag, "_ack"}, {31'b0, ready}, 32'd1);
    @(negedge clk); wmask = '0;
    @(posedge clk); #1 chk({tag, "_drop"}, {31'b0, ready}, 32'd0);
  endtask

  // Access that must never be acknowledged.
  task automatic nack(input string tag, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    @(negedge clk); addr = a; wmask = m; wdata = d;
    @(posedge clk); #1 chk({tag, "_c1"}, {31'b0, ready}, 32'd0);
    @(posedge clk); #1 chk({tag, "_c2"}, {31'b0, ready}, 32'd0);
    @(negedge clk); wmask = '0;
  endtask

  task automatic chk_state(input string tag, input logic [15:0] p, input logic [15:0] f,
                           input logic [31:0] id, input logic [31:0] code);
    chk({tag, "_pass"}, {16'b0, pass_cnt}, {16'b0, p});
    chk({tag, "_fail"}, {16'b0, fail_cnt}, {16'b0, f});
    chk({tag, "_lfid"}, lf_id, id);
    chk({tag, "_lfcode"}, lf_code, code);
  endtask

  initial begin
    #12;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk_state("rst", 16'd0, 16'd0, 32'd0, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    @(negedge clk); resetn = 1'b1;

    // Basic pass
    wr("tid5", 32'h1000_0000, 4'hF, 32'd5);
    wr("res0", 32'h1000_0004, 4'hF, 32'd0);
    chk_state("pass1", 16'd1, 16'd0, 32'd0, 32'd0);

    // Failure record
    wr("tid7", 32'h1000_0000, 4'hF, 32'd7);
    wr("resdead", 32'h1000_0004, 4'hF, 32'h0000_DEAD);
    chk_state("fail1", 16'd1, 16'd1, 32'd7, 32'h0000_DEAD);

    // Read in window and write outside window
    nack("read", 32'h1000_0004, 4'h0, 32'd1);
    nack("outside", 32'h0000_1000, 4'hF, 32'd0);
    nack("near", 32'h1000_0014, 4'hF, 32'd9);
    chk_state("noeff", 16'd1, 16'd1, 32'd7, 32'h0000_DEAD);

    // Held request: acked every second cycle
    @(negedge clk); addr = 32'h1000_0004; wmask = 4'hF; wdata = 32'd0;
    @(posedge clk); #1 chk("hold_e1", {31'b0, ready}, 32'd1);
    @(posedge clk); #1 chk("hold_e2", {31'b0, ready}, 32'd0);
    @(posedge clk); #1 chk("hold_e3", {31'b0, ready}, 32'd1);
    @(posedge clk); #1 chk("hold_e4", {31'b0, ready}, 32'd0);
    @(negedge clk); wmask = '0;
    chk("hold_pass", {16'b0, pass_cnt}, 32'd3);

    // Narrow instance saturates at 3
    wr("res0b", 32'h1000_0004, 4'hF, 32'd0);
    wr("res0c", 32'h1000_0004, 4'hF, 32'd0);
    chk("wide_pass5", {16'b0, pass_cnt}, 32'd5);
    chk("sat_pass", {30'b0, s_pass}, 32'd3);

    // Single strobe still uses full data word
    wr("res_mask", 32'h1000_0004, 4'h1, 32'h0000_0100);
    chk_state("fail2", 16'd5, 16'd2, 32'd7, 32'h0000_0100);

    // Offset 0xC acked and ignored
    wr("offc", 32'h1000_000C, 4'hF, 32'hFFFF_FFFF);
    chk_state("offc", 16'd5, 16'd2, 32'd7, 32'h0000_0100);
    chk("offc_done", {31'b0, done}, 32'd0);

    // DONE and lockout
    wr("done", 32'h1000_0008, 4'hF, 32'h0000_002A);
    chk("done_flag", {31'b0, done}, 32'd1);
    chk("exit", exit_code, 32'h0000_002A);
    wr("post_res", 32'h1000_0004, 4'hF, 32'd1);
    wr("post_done", 32'h1000_0008, 4'hF, 32'h0000_0055);
    chk_state("post", 16'd5, 16'd2, 32'd7, 32'h0000_0100);
    chk("post_exit", exit_code, 32'h0000_002A);

    // Async reset while ready is high
    @(negedge clk); addr = 32'h1000_0004; wmask = 4'hF; wdata = 32'd0;
    @(posedge clk); #1 chk("arst_pre", {31'b0, ready}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("arst_ready", {31'b0, ready}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_exit", exit_code, 32'd0);
    chk_state("arst", 16'd0, 16'd0, 32'd0, 32'd0);
    chk("arst_s_pass", {30'b0, s_pass}, 32'd0);
    wmask = '0;
    @(negedge clk); resetn = 1'b1;

    // Test id cleared by reset: a failure now records id 0
    wr("rres", 32'h1000_0004, 4'hF, 32'd3);
    chk_state("after_rst", 16'd0, 16'd1, 32'd0, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/unit_test.md
UNIT_TEST -- requirements
Module: unit_test

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h1000_0000, meaning the byte base of a 16-byte register window.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the pass/fail counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port dmem_addr, input, 32 bits: the CPU byte address.
REQ-006 The block SHALL have port dmem_wmask, input, 4 bits: the CPU byte write strobes; nonzero means write.
REQ-007 The block SHALL have port dmem_wdata, input, 32 bits: the CPU write data.
REQ-008 The block SHALL have port dmem_ready, output, 1 bit: the write acknowledge, ORed with other slaves at SoC level.
REQ-009 The block SHALL have port done, output, 1 bit: the test run finished (sticky).
REQ-010 The block SHALL have ports pass_cnt and fail_cnt, output, CNT_W bits each: the result counters.
REQ-011 The block SHALL have ports last_fail_id and last_fail_code, output, 32 bits each: the most recent failure record.
REQ-012 The block SHALL have port exit_code, output, 32 bits: the value written to DONE.

Function
REQ-013 Hit SHALL be asserted when |dmem_wmask, dmem_addr[31:4]==BASE_ADDR[31:4] and !dmem_ready; there is no valid input, so a nonzero wmask qualifies the access.
REQ-014 dmem_ready SHALL be registered and equal hit of the previous cycle, giving a one-cycle pulse one cycle after the write is presented; back-to-back held requests SHALL be acked every second cycle.
REQ-015 Reads (wmask==0) and addresses outside the window SHALL never assert dmem_ready; software SHALL not read the window.
REQ-016 Register writes SHALL take effect on the hit edge, using the full dmem_wdata for any nonzero wmask.
REQ-017 Offset 0x0 TEST_ID: the write SHALL store the current test id internally.
REQ-018 Offset 0x4 RESULT: wdata==0 SHALL increment pass_cnt; nonzero SHALL increment fail_cnt and load last_fail_id<=TEST_ID and last_fail_code<=wdata.
REQ-019 A RESULT write in the same cycle as nothing else SHALL use the TEST_ID value committed before that cycle; one write completes per ack, so no simultaneous register updates exist.
REQ-020 Offset 0x8 DONE: the write SHALL set done=1 and exit_code<=wdata.
REQ-021 Offset 0xC and unused bits SHALL be acked and ignored.
REQ-022 Counters SHALL saturate at all-ones and not wrap.
REQ-023 After done=1, writes SHALL still be acked but SHALL change no state.

Reset
REQ-024 resetn low SHALL asynchronously clear dmem_ready, done, pass_cnt, fail_cnt, last_fail_id, last_fail_code, exit_code and TEST_ID to 0.
REQ-025 Reset asserted mid-handshake SHALL drop dmem_ready immediately; the pending write SHALL be lost.

Configuration
REQ-026 With UNIT_TEST_LOG_EN defined, the block SHALL $display each RESULT as "test <id> PASS" or "test <id> FAIL code <hex>", and on DONE SHALL print the pass/fail totals and call $finish.
REQ-027 Without UNIT_TEST_LOG_EN, the block SHALL produce no simulation output and no $finish; the hardware behaviour SHALL be identical.

Structure
REQ-028 Package unit_test_pkg SHALL hold the register offsets (OFF_TEST_ID, OFF_RESULT, OFF_DONE) and the default BASE_ADDR and CNT_W.
REQ-029 Sub-module sat_counter (parameter width, inc, saturating) SHALL be instantiated twice, once for pass_cnt and once for fail_cnt.

Verification
REQ-030 Reset release, then write 0x1000_0000<=5 and 0x1000_0004<=0 -> each ready pulse is 1 cycle, one cycle after the request; pass_cnt=1, fail_cnt=0.
REQ-031 Write TEST_ID=7 then RESULT=0xDEAD -> fail_cnt=1, last_fail_id=7, last_fail_code=0xDEAD.
REQ-032 Read at 0x1000_0004, and write at 0x0000_1000 -> dmem_ready stays 0 and no state changes.
REQ-033 Write held for 4 cycles -> ready pulses on cycles 2 and 4 and pass_cnt increments by 2; CNT_W=2 with 5 passes -> pass_cnt=3.
REQ-034 Write DONE=0x2A, then RESULT=1 -> done=1 and exit_code=0x2A; the RESULT write is acked but fail_cnt is unchanged; with UNIT_TEST_LOG_EN defined, simulation ends.
REQ-035 Assert resetn low while ready=1 -> ready and all outputs read 0 without waiting for a clock edge.
